// File: rtl/fwd_sel_gen.sv
// EX-stage operand forwarding select generator with load-use stall detection.
// Optional FWD_PERF_CNT_EN adds a saturating stall_cnt output.
module fwd_sel_gen #(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_rd_we,
  input  logic                  id_is_load,
  input  logic                  hold,
  input  logic                  flush,
  output logic                  stall,
`ifdef FWD_PERF_CNT_EN
  output logic [31:0]           stall_cnt,
`endif
  output logic [2:0]            ex_sel_rs1,
  output logic [2:0]            ex_sel_rs2
);

  localparam logic [2:0] SelRf  = 3'b001;
  localparam logic [2:0] SelMem = 3'b010;
  localparam logic [2:0] SelWb  = 3'b100;

  // EX record kept in full; only the "writes rd" summary of MEM is needed downstream.
  // The WB record has no consumer because the register file covers that distance.
  logic                  ex_valid_q, ex_we_q, ex_is_load_q;
  logic [REG_ADDR_W-1:0] ex_rd_q;
  logic                  mem_wr_q;
  logic [REG_ADDR_W-1:0] mem_rd_q;

  logic                  ex_wr;
  logic                  take;
  logic [2:0]            sel_rs1_d, sel_rs2_d;

  assign ex_wr = ex_valid_q & ex_we_q & (ex_rd_q != '0);

  always_comb begin
    stall = id_valid & ~flush & ex_valid_q & ex_is_load_q & ex_we_q & (ex_rd_q != '0) &
            ((id_rs1_used & (id_rs1 == ex_rd_q)) | (id_rs2_used & (id_rs2 == ex_rd_q)));
  end

  assign take = id_valid & ~stall & ~flush;

  function automatic logic [2:0] sel_for(input logic used, input logic [REG_ADDR_W-1:0] rs,
                                         input logic ex_w, input logic [REG_ADDR_W-1:0] ex_r,
                                         input logic mem_w, input logic [REG_ADDR_W-1:0] mem_r);
    logic [2:0] s;
    s = SelRf;
    if (used && rs != '0) begin
      if (ex_w && ex_r == rs) begin
        s = SelMem;
      end else if (mem_w && mem_r == rs) begin
        s = SelWb;
      end
    end
    return s;
  endfunction

  always_comb begin
    sel_rs1_d = SelRf;
    sel_rs2_d = SelRf;
    if (take) begin
      sel_rs1_d = sel_for(id_rs1_used, id_rs1, ex_wr, ex_rd_q, mem_wr_q, mem_rd_q);
      sel_rs2_d = sel_for(id_rs2_used, id_rs2, ex_wr, ex_rd_q, mem_wr_q, mem_rd_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid_q   <= 1'b0;
      ex_we_q      <= 1'b0;
      ex_is_load_q <= 1'b0;
      ex_rd_q      <= '0;
      mem_wr_q     <= 1'b0;
      mem_rd_q     <= '0;
      ex_sel_rs1   <= SelRf;
      ex_sel_rs2   <= SelRf;
    end else begin
      if (!hold) begin
        mem_wr_q <= ex_wr;
        mem_rd_q <= ex_rd_q;
      end
      // Flush overrides hold for the EX slot so a killed instruction never lingers.
      if (flush || !hold) begin
        ex_valid_q   <= take;
        ex_we_q      <= take & id_rd_we;
        ex_is_load_q <= take & id_is_load;
        ex_rd_q      <= take ? id_rd : '0;
        ex_sel_rs1   <= sel_rs1_d;
        ex_sel_rs2   <= sel_rs2_d;
      end
    end
  end

`ifdef FWD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall && !hold && stall_cnt != 32'hFFFF_FFFF) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fwd_sel_gen.sv
// Directed plus randomized bench for fwd_sel_gen against a pipeline-array reference model.
module tb_fwd_sel_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_rs1_used, id_rs2_used, id_rd_we, id_is_load;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       hold, flush;
  logic       stall;
  logic [2:0] ex_sel_rs1, ex_sel_rs2;
`ifdef FWD_PERF_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  fwd_sel_gen #(.REG_ADDR_W(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .id_rd       (id_rd),
    .id_rd_we    (id_rd_we),
    .id_is_load  (id_is_load),
    .hold        (hold),
    .flush       (flush),
    .stall       (stall),
`ifdef FWD_PERF_CNT_EN
    .stall_cnt   (stall_cnt),
`endif
    .ex_sel_rs1  (ex_sel_rs1),
    .ex_sel_rs2  (ex_sel_rs2)
  );

  always #5 clk = ~clk;

  // Reference: pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB.
  typedef struct {
    logic       v;
    logic [4:0] rd;
    logic       we;
    logic       ld;
  } rec_t;

  rec_t        pipe[3];
  logic [2:0]  m_sel1 = 3'b001;
  logic [2:0]  m_sel2 = 3'b001;
  longint      m_cnt  = 0;

  function automatic logic m_stall();
    if (!id_valid || flush || !pipe[0].v || !pipe[0].ld || !pipe[0].we || pipe[0].rd == 0)
      return 1'b0;
    return (id_rs1_used && id_rs1 == pipe[0].rd) || (id_rs2_used && id_rs2 == pipe[0].rd);
  endfunction

  // Select points at the youngest in-flight producer, encoded by its distance.
  function automatic logic [2:0] m_sel(input logic used, input logic [4:0] rs);
    if (!used || rs == 0) return 3'b001;
    for (int d = 0; d < 2; d++) begin
      if (pipe[d].v && pipe[d].we && pipe[d].rd == rs) return 3'(1 << (d + 1));
    end
    return 3'b001;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic present(input logic v, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                         input logic we, input logic ld);
    id_valid = v; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
    id_rd = rd; id_rd_we = we; id_is_load = ld;
    #1;
  endtask

  task automatic idle();
    present(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic clock();
    logic       st;
    logic [2:0] s1, s2;
    rec_t       nrec;
    st = m_stall();
    check("stall", {31'd0, stall}, {31'd0, st});
    s1 = m_sel(id_rs1_used, id_rs1);
    s2 = m_sel(id_rs2_used, id_rs2);
    nrec.v = id_valid; nrec.rd = id_rd; nrec.we = id_rd_we; nrec.ld = id_is_load;
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) pipe[i].v = 1'b0;
      m_sel1 = 3'b001; m_sel2 = 3'b001; m_cnt = 0;
    end else begin
      if (!hold) begin
        if (st && m_cnt < 64'hFFFF_FFFF) m_cnt++;
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
      end
      if (flush || !hold) begin
        if (id_valid && !st && !flush) begin
          pipe[0] = nrec; m_sel1 = s1; m_sel2 = s2;
        end else begin
          pipe[0].v = 1'b0; m_sel1 = 3'b001; m_sel2 = 3'b001;
        end
      end
    end
    #1;
    check("sel_rs1", {29'd0, ex_sel_rs1}, {29'd0, m_sel1});
    check("sel_rs2", {29'd0, ex_sel_rs2}, {29'd0, m_sel2});
`ifdef FWD_PERF_CNT_EN
    check("stall_cnt", stall_cnt, m_cnt[31:0]);
`endif
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      pipe[i].v = 1'b0; pipe[i].rd = '0; pipe[i].we = 1'b0; pipe[i].ld = 1'b0;
    end
    rst_n = 1'b0; hold = 1'b0; flush = 1'b0;
    idle();
    // Reset for two cycles
    clock(); clock();
    check("rst_sel1", {29'd0, ex_sel_rs1}, 32'd1);
    check("rst_sel2", {29'd0, ex_sel_rs2}, 32'd1);
    check("rst_stall", {31'd0, stall}, 32'd0);
    rst_n = 1'b1;
    // First instruction reads register file
    present(1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 5'd1, 1'b1, 1'b0); clock();
    check("first_rf", {26'd0, ex_sel_rs1, ex_sel_rs2}, 32'o11);
    // EX forward
    present(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0); clock();
    present(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd20, 1'b0, 1'b0); clock();
    check("ex_fwd_rs1", {29'd0, ex_sel_rs1}, 32'b010);
    check("ex_fwd_rs2", {29'd0, ex_sel_rs2}, 32'b001);
    // WB forward
    present(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0); clock();
    present(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0); clock();
    present(1'b1, 5'd1, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0); clock();
    check("wb_fwd_rs2", {29'd0, ex_sel_rs2}, 32'b100);
    // Younger writer wins
    present(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0); clock();
    present(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0); clock();
    present(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0); clock();
    check("prio_rs2", {29'd0, ex_sel_rs2}, 32'b010);
    // Load-use
    present(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1); clock();
    present(1'b1, 5'd8, 1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0);
    check("lu_stall", {31'd0, stall}, 32'd1);
    clock();
    check("lu_bubble", {26'd0, ex_sel_rs1, ex_sel_rs2}, 32'o11);
    check("lu_stall_gone", {31'd0, stall}, 32'd0);
    clock();
    check("lu_retry_rs1", {29'd0, ex_sel_rs1}, 32'b100);
`ifdef FWD_PERF_CNT_EN
    check("lu_cnt", stall_cnt, 32'd1);
`endif
    // x0 never forwards or stalls
    present(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1); clock();
    present(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd1, 1'b1, 1'b0);
    check("x0_stall", {31'd0, stall}, 32'd0);
    clock();
    check("x0_sel1", {29'd0, ex_sel_rs1}, 32'b001);
    // Unused rs2
    present(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0); clock();
    present(1'b1, 5'd1, 1'b1, 5'd10, 1'b0, 5'd0, 1'b0, 1'b0); clock();
    check("unused_rs2", {29'd0, ex_sel_rs2}, 32'b001);
    // Flush during load-use
    present(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1, 1'b1); clock();
    flush = 1'b1;
    present(1'b1, 5'd11, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0);
    check("flush_stall", {31'd0, stall}, 32'd0);
    clock();
    check("flush_sel", {26'd0, ex_sel_rs1, ex_sel_rs2}, 32'o11);
    flush = 1'b0;
    // Hold keeps selects
    present(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0); clock();
    present(1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); clock();
    check("hold_pre", {29'd0, ex_sel_rs1}, 32'b010);
    hold = 1'b1;
    present(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd13, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      clock();
      check("hold_keep", {29'd0, ex_sel_rs1}, 32'b010);
    end
    hold = 1'b0;
    clock();
    present(1'b1, 5'd13, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); clock();
    check("hold_resume", {29'd0, ex_sel_rs1}, 32'b010);
    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      hold  = ($urandom_range(0, 9) == 0);
      flush = ($urandom_range(0, 9) == 0);
      present(1'($urandom_range(0, 5) != 0), 5'($urandom_range(0, 7)), 1'($urandom),
              5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)),
              1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0));
      clock();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
